reg_bank_ab: RTL and testbench
==============================

# reg_bank_ab

Multicycle datapath register bank: a 32 x 32-bit general-purpose register file with the write-destination and write-data muxes and the A/B operand latches. It sits directly downstream of the multicycle control unit and consumes its `RegWrite`, `RegDst`, `MemtoReg`, `AWrite` and `BWrite` strobes. It feeds the A/B registers into the ALU source muxes. After every reset, a built-in clear sequencer zeroes the array and holds `Busy` high until the bank is usable.

## Interface
Clocking and reset: one clock; reset is synchronous and active-high. The clock port is `Clk` and the reset port is `Reset`.

Parameters:
- `DATA_W`, default 32: register and datapath width.
- `NREGS`, default 32: number of registers. Fixed at 32 because of the 5-bit `Rs`/`Rt`/`Rd` fields.

Ports:
- `Clk`, input, 1: clock. All state updates on the rising edge.
- `Reset`, input, 1: synchronous, active-high. Restarts the clear sequence.
- `RegWrite`, input, 1: write enable for the register array.
- `RegDst`, input, 1: destination select. 0 selects `Rt`, 1 selects `Rd`.
- `MemtoReg`, input, 1: write-data select. 0 selects `ALUOut`, 1 selects `MDR`.
- `AWrite`, input, 1: load the A latch from `Rs`.
- `BWrite`, input, 1: load the B latch from `Rt`.
- `Rs`, input, 5: instruction bits [25:21].
- `Rt`, input, 5: instruction bits [20:16].
- `Rd`, input, 5: instruction bits [15:11].
- `ALUOut`, input, DATA_W: ALU output register.
- `MDR`, input, DATA_W: memory data register.
- `A`, output, DATA_W: operand latch A.
- `B`, output, DATA_W: operand latch B.
- `Busy`, output, 1: clear sequence in progress. The bank ignores all strobes while `Busy` is 1.

## Operation
- State machine: two states, `CLEAR` and `RUN`. A 5-bit counter `clr_cnt` drives the clear.
- `Reset`=1 at an edge:
  - state <= `CLEAR`; `clr_cnt` <= 0.
  - `A` <= 0; `B` <= 0; `Busy` = 1.
  - The array is not written on this edge.
- `CLEAR`, `Reset`=0, each edge:
  - reg[`clr_cnt`] <= 0; `clr_cnt` <= `clr_cnt` + 1.
  - On the edge that clears reg[31], state <= `RUN`.
  - `RegWrite`, `AWrite` and `BWrite` are ignored. `A` and `B` hold 0.
- `RUN`: `Busy`=0.
- Write path:
  - `waddr` = `RegDst` ? `Rd` : `Rt`.
  - `wdata` = `MemtoReg` ? `MDR` : `ALUOut`.
  - reg[`waddr`] <= `wdata` on an edge with `RegWrite`=1.
- Register 0: a write with `waddr`=0 is discarded, and reads of index 0 always return 0.
- Read path:
  - The array is read combinationally by `Rs` and `Rt`.
  - `A` <= read(`Rs`) when `AWrite`=1, else `A` holds.
  - `B` <= read(`Rt`) when `BWrite`=1, else `B` holds.
- Simultaneous write and latch to the same index: behaviour is set by `REG_BYPASS_EN` (see Configuration).
- Strobe combinations: `RegWrite`, `AWrite` and `BWrite` may all be active on the same edge. They are independent of each other.

## Timing
- Reset values:
  - `A`=0, `B`=0, `Busy`=1.
  - All registers read 0 once the clear completes.
- Clear latency: `Busy` is 1 for exactly 32 rising edges after `Reset` falls. It reads 0 after the 32nd edge.
- Reset during the clear or during `RUN`: the next edge restarts the sequence from `clr_cnt`=0.
- Write latency: a write is visible to the combinational read one edge after the `RegWrite` edge.
- A/B latency: `A` and `B` update on the edge where `AWrite`/`BWrite` is sampled high. The new value is visible in the following cycle, which matches DECODE feeding the execute state.
- No handshake: the control unit must not leave FETCH before `Busy`=0. This block does not stall the control unit.

## Configuration
- Macro: `REG_BYPASS_EN`.
- With `REG_BYPASS_EN` defined: when `RegWrite`=1, `waddr`≠0 and `waddr`==`Rs` on an edge with `AWrite`=1, `A` latches `wdata`. The same rule applies to `B` with `Rt` and `BWrite`. This is write-through forwarding.
- Without `REG_BYPASS_EN`: `A`/`B` latch the pre-write array value. The new value is visible only on the next latch.

## Test plan
- Reset clear: preload reg[5]=32'hDEAD_BEEF, pulse `Reset` for 1 cycle, then hold strobes at 0.
  - `Busy` is 1 for 32 edges, then 0.
  - Then `Rs`=5 with `AWrite` gives `A`=0.
- Write mux:
  - `RegDst`=1, `Rd`=9, `MemtoReg`=0, `ALUOut`=32'h0000_1234, `RegWrite`=1; next cycle `Rs`=9 with `AWrite` gives `A`=32'h0000_1234.
  - `RegDst`=0, `Rt`=10, `MemtoReg`=1, `MDR`=32'hCAFE_0001; next cycle `Rt`=10 with `BWrite` gives `B`=32'hCAFE_0001.
- $zero: write 32'hFFFF_FFFF to index 0; `Rs`=`Rt`=0 with `AWrite` and `BWrite` gives `A`=`B`=0.
- Strobes ignored while busy: `RegWrite`=1 to reg 3 and `AWrite`=1 during `CLEAR`.
  - `A` stays 0.
  - reg 3 reads 0 once `Busy`=0.
- Same-edge write and latch: reg 7 holds 32'h11; write 32'h22 to reg 7 with `AWrite`=1 and `Rs`=7 on the same edge.
  - `A`=32'h22 with `REG_BYPASS_EN`, 32'h11 without.
  - The next `AWrite` gives 32'h22 in both builds.
- Reset mid-clear: assert `Reset` at clear edge 10.
  - `Busy` stays 1 for another 32 edges after `Reset` falls.
  - All registers read 0 afterwards.

Source files
------------

// File: rtl/reg_bank_ab.sv
// ============================================================================
// Module   : reg_bank_ab
// Purpose  : Multicycle datapath register bank. A 32 x DATA_W register file
//            with destination and write-data muxes and the A/B operand
//            latches. A clear sequencer zeroes the array after every reset
//            and holds Busy high until the bank is usable.
// Options  : REG_BYPASS_EN - when defined, a same-edge write to the index
//            being latched into A/B is forwarded into the latch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_ab #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic              RegDst,
  input  logic              MemtoReg,
  input  logic              AWrite,
  input  logic              BWrite,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              Busy
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [4:0] c_LAST_IDX = 5'd31;

  state_t            r_state;
  state_t            w_state_next;
  logic [4:0]        r_clr_cnt;
  logic [DATA_W-1:0] r_regs [NREGS];

  logic [4:0]        w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;
  logic [DATA_W-1:0] w_a_next;
  logic [DATA_W-1:0] w_b_next;

  // Write destination / data muxes; index 0 is never a real destination.
  assign w_waddr = RegDst ? Rd : Rt;
  assign w_wdata = MemtoReg ? MDR : ALUOut;
  assign w_wr_en = RegWrite && (w_waddr != 5'd0);

  // Combinational reads with $zero forced to 0 regardless of array content.
  assign w_rdata_a = (Rs == 5'd0) ? '0 : r_regs[Rs];
  assign w_rdata_b = (Rt == 5'd0) ? '0 : r_regs[Rt];

`ifdef REG_BYPASS_EN
  // Write-through forwarding: a latch on the same edge as a write to the
  // same nonzero index captures the new data instead of the stale entry.
  assign w_a_next = (w_wr_en && (w_waddr == Rs)) ? w_wdata : w_rdata_a;
  assign w_b_next = (w_wr_en && (w_waddr == Rt)) ? w_wdata : w_rdata_b;
`else
  // Latches capture the pre-write array value.
  assign w_a_next = w_rdata_a;
  assign w_b_next = w_rdata_b;
`endif

  assign Busy = (r_state == S_CLEAR);

  // State register and clear counter; reset restarts the clear from index 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= 5'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 5'd1;
      end
    end
  end

  // Leave CLEAR on the edge that zeroes the last register.
  always_comb begin
    w_state_next = r_state;
    if ((r_state == S_CLEAR) && (r_clr_cnt == c_LAST_IDX)) begin
      w_state_next = S_RUN;
    end
  end

  // Array update: clear one entry per edge while busy, otherwise normal writes.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (r_state == S_CLEAR) begin
        r_regs[r_clr_cnt] <= '0;
      end else if (w_wr_en) begin
        r_regs[w_waddr] <= w_wdata;
      end
    end
  end

  // Operand latches: zero during reset and clear, load on their strobes in RUN.
  always_ff @(posedge Clk) begin
    if (Reset || (r_state == S_CLEAR)) begin
      A <= '0;
      B <= '0;
    end else begin
      if (AWrite) begin
        A <= w_a_next;
      end
      if (BWrite) begin
        B <= w_b_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_ab.sv
// ============================================================================
// Module   : tb_reg_bank_ab
// Purpose  : Directed self-checking bench for reg_bank_ab.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_ab;

  logic        Clk;
  logic        Reset;
  logic        RegWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        AWrite;
  logic        BWrite;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [31:0] ALUOut;
  logic [31:0] MDR;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;

  int r_vectors;
  int r_errors;

  reg_bank_ab #(.DATA_W(32), .NREGS(32)) u_dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .AWrite   (AWrite),
    .BWrite   (BWrite),
    .Rs       (Rs),
    .Rt       (Rt),
    .Rd       (Rd),
    .ALUOut   (ALUOut),
    .MDR      (MDR),
    .A        (A),
    .B        (B),
    .Busy     (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_vectors++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; AWrite = 0; BWrite = 0;
  endtask

  task automatic wr(input logic dst, input logic [4:0] rt, input logic [4:0] rd,
                    input logic m2r, input logic [31:0] alu, input logic [31:0] mdr);
    RegDst = dst; Rt = rt; Rd = rd; MemtoReg = m2r; ALUOut = alu; MDR = mdr;
    RegWrite = 1;
    step();
    RegWrite = 0;
  endtask

  task automatic read_a(input logic [4:0] idx, output logic [31:0] val);
    Rs = idx; AWrite = 1;
    step();
    AWrite = 0;
    val = A;
  endtask

  task automatic read_b(input logic [4:0] idx, output logic [31:0] val);
    Rt = idx; BWrite = 1;
    step();
    BWrite = 0;
    val = B;
  endtask

  // Counts edges until Busy drops, bounded so a stuck Busy cannot hang.
  task automatic wait_clear(output int n);
    n = 0;
    while (Busy && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_reset();
    Reset = 1;
    step();
    Reset = 0;
  endtask

  initial begin
    logic [31:0] v;
    int n;
    int bad;
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    r_vectors = 0;
    r_errors  = 0;
    Reset = 1; RegDst = 0; MemtoReg = 0; Rs = 0; Rt = 0; Rd = 0;
    ALUOut = 0; MDR = 0;
    idle();

    // Reset state
    step();
    chk("rst_A", A, 32'h0);
    chk("rst_B", B, 32'h0);
    chk("rst_Busy", {31'b0, Busy}, 32'h1);
    Reset = 0;
    wait_clear(n);
    chk("clr_len", n, 32);

    // Preload reg 5, then reset must wipe it
    wr(1'b1, 5'd0, 5'd5, 1'b0, 32'hDEAD_BEEF, 32'h0);
    read_a(5'd5, v);
    chk("preload5", v, 32'hDEAD_BEEF);
    pulse_reset();
    chk("rst2_Busy", {31'b0, Busy}, 32'h1);
    wait_clear(n);
    chk("clr_len2", n, 32);
    read_a(5'd5, v);
    chk("clr_reg5", v, 32'h0);

    // Write mux: Rd/ALUOut and Rt/MDR
    wr(1'b1, 5'd0, 5'd9, 1'b0, 32'h0000_1234, 32'h0);
    read_a(5'd9, v);
    chk("wmux_rd_alu", v, 32'h0000_1234);
    wr(1'b0, 5'd10, 5'd0, 1'b1, 32'h0, 32'hCAFE_0001);
    read_b(5'd10, v);
    chk("wmux_rt_mdr", v, 32'hCAFE_0001);

    // $zero: write discarded, read forced to 0 (A/B previously nonzero)
    wr(1'b1, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    Rs = 0; Rt = 0; AWrite = 1; BWrite = 1;
    step();
    idle();
    chk("zero_A", A, 32'h0);
    chk("zero_B", B, 32'h0);

    // Strobes ignored while busy
    pulse_reset();
    RegDst = 1; Rd = 5'd3; MemtoReg = 0; ALUOut = 32'h0000_ABCD;
    RegWrite = 1; AWrite = 1; BWrite = 1; Rs = 5'd9; Rt = 5'd10;
    n = 0; bad = 0;
    while (Busy && n < 40) begin
      step();
      n++;
      if (A != 0 || B != 0) bad++;
    end
    idle();
    chk("busy_clr_len", n, 32);
    chk("busy_AB_nonzero", bad, 0);
    read_a(5'd3, v);
    chk("busy_reg3", v, 32'h0);

    // Same-edge write and latch
    wr(1'b1, 5'd0, 5'd7, 1'b0, 32'h11, 32'h0);
    RegDst = 1; Rd = 5'd7; MemtoReg = 0; ALUOut = 32'h22;
    Rs = 5'd7; RegWrite = 1; AWrite = 1;
    step();
    idle();
`ifdef REG_BYPASS_EN
    exp_a = 32'h22;
    exp_b = 32'h33;
`else
    exp_a = 32'h11;
    exp_b = 32'h22;
`endif
    chk("same_edge_A", A, exp_a);
    read_a(5'd7, v);
    chk("next_latch_A", v, 32'h22);
    RegDst = 0; Rt = 5'd7; MemtoReg = 1; MDR = 32'h33;
    RegWrite = 1; BWrite = 1;
    step();
    idle();
    chk("same_edge_B", B, exp_b);
    read_b(5'd7, v);
    chk("next_latch_B", v, 32'h33);

    // Reset mid-clear: preload, restart at clear edge 10
    wr(1'b1, 5'd0, 5'd12, 1'b0, 32'h77, 32'h0);
    wr(1'b1, 5'd0, 5'd31, 1'b0, 32'h99, 32'h0);
    pulse_reset();
    for (int i = 0; i < 10; i++) step();
    chk("mid_Busy", {31'b0, Busy}, 32'h1);
    pulse_reset();
    wait_clear(n);
    chk("mid_clr_len", n, 32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      read_a(i[4:0], v);
      if (v != 0) bad++;
    end
    chk("mid_all_zero", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_errors);
    $finish;
  end

endmodule

`default_nettype wire
